cameralink_tx_timing: RTL and testbench
=======================================

Name: cameralink_tx_timing

Overview:
- Transmit-side Camera Link video timing generator on data_clk.
- Pulls pixels from an upstream standard-mode FIFO (1-cycle read latency).
- Emits frame_valid / line_valid / data_valid / dout with programmable blanking, driving the serializer toward the camera-side link.
- Frame geometry comes from runtime app_image_h / app_image_w; blanking comes from parameters.

Parameters:
FV_TO_LV, 2, cycles FVAL high before the first LVAL of a frame (min 1)
H_BLANK, 16, LVAL-low cycles between lines within a frame (min 1)
LV_TO_FV, 2, cycles FVAL stays high after the last LVAL (min 1)
V_BLANK, 64, FVAL-low cycles between frames (min 1)

Ports:
data_clk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  level; permits starting a new frame
app_image_h  in  16  lines per frame; sampled at frame start
app_image_w  in  16  pixels per line; sampled at frame start
pix_rd_en  out  1  upstream FIFO read strobe
pix_din  in  16  upstream FIFO data; valid the cycle after pix_rd_en
pix_empty  in  1  upstream FIFO empty
frame_valid  out  1  Camera Link FVAL
line_valid  out  1  Camera Link LVAL
data_valid  out  1  Camera Link DVAL (equal to line_valid)
dout  out  16  pixel data
frame_done  out  1  1-cycle pulse on the cycle frame_valid falls
underflow  out  1  sticky: read attempted while pix_empty

Behaviour:
- Reset: state S_IDLE, all counters 0, all outputs 0 (pix_rd_en, frame_valid, line_valid, data_valid, dout, frame_done, underflow).
- States and transitions:
  - S_IDLE: go to S_FV_PRE when enable=1 and both sampled dimensions are nonzero.
  - On leaving S_IDLE, latch H=app_image_h and W=app_image_w. If either is 0, remain in S_IDLE and start no frame.
  - S_FV_PRE: FV_TO_LV cycles, then S_LINE.
  - S_LINE: W cycles, then S_HBLANK if more lines remain, else S_FV_POST.
  - S_HBLANK: H_BLANK cycles, then S_LINE.
  - S_FV_POST: LV_TO_FV cycles, then S_VBLANK.
  - S_VBLANK: V_BLANK cycles, then S_FV_PRE if enable=1 (re-latch and re-check dimensions), else S_IDLE.
- Counters: 16-bit pixel counter, line counter and blank counter. Pixel and blank counters reset to 0 on every state change. The line counter increments at the end of each S_LINE. Max W, H = 65535; no wrap within a frame.
- Internal signals: fv_i = 1 in S_FV_PRE/S_LINE/S_HBLANK/S_FV_POST. lv_i = 1 in S_LINE.
- pix_rd_en = lv_i, decoded from the registered state (glitch-free, no pipeline delay).
- Output pipeline, fixed 2-cycle latency from internal state:
  - frame_valid, line_valid and data_valid are fv_i / lv_i delayed 2 cycles.
  - dout is registered from pix_din when lv_i delayed 1 cycle = 1; otherwise dout = 0.
  - Pixel read on cycle t is on dout at t+2, aligned with line_valid.
- Underflow: if pix_rd_en=1 and pix_empty=1 on a cycle, set underflow. That pixel is output as 0x0000 and timing is unaffected.
  - underflow clears only on reset or on the S_IDLE/S_VBLANK→S_FV_PRE transition.
  - If clear and set coincide, set wins.
- enable deasserted mid-frame: the current frame completes including V_BLANK, then S_IDLE.
- app_image_h / app_image_w changes mid-frame are ignored until the next frame start.
- frame_done: registered; asserted on the cycle frame_valid goes 1→0.
- Reset mid-frame: all outputs drop to 0 asynchronously; the next frame begins cleanly with FV_PRE.
- Frame lengths:
  - FVAL-high length = FV_TO_LV + H*W + (H-1)*H_BLANK + LV_TO_FV.
  - Back-to-back period = FVAL-high length + V_BLANK.

Test Plan:
1. Params 2/3/4/5, H=3, W=4, enable held, FIFO never empty.
   - frame_valid high exactly 24 cycles, low 5, period 29.
   - Three LVAL bursts of 4 separated by 3 low cycles; first LVAL 2 cycles after FVAL rises.
   - frame_done pulses once per frame.
2. FIFO supplies 0x0000,0x0001,… → dout shows incrementing values only while line_valid=1.
   - dout is 0 otherwise; 12 pixels per frame, no drops or repeats.
   - Each pixel is on dout 2 cycles after its pix_rd_en.
3. Force pix_empty=1 for the 3rd read of line 2.
   - underflow=1 from 2 cycles later until the next frame start; that pixel = 0x0000.
   - Frame timing is unchanged.
4. Deassert enable in the middle of line 2.
   - Frame finishes with all 3 lines; after V_BLANK the block sits in S_IDLE, frame_valid=0, pix_rd_en=0.
   - Reassert enable → the new FVAL rises 1 cycle after leaving S_IDLE plus 2-cycle output latency.
5. Dimension handling.
   - app_image_w=0 with enable=1 → no FVAL ever.
   - Change to W=2, H=1 → a single 2-pixel line; FVAL high 2+2+4=8 cycles.
   - Changing W mid-frame has no effect until the next frame.
6. Pulse rst_n low during S_LINE.
   - All outputs 0 immediately.
   - After release, the first frame matches scenario 1 timing exactly.

Source files
------------

// File: rtl/cameralink_tx_timing.sv
// cameralink_tx_timing
//   Transmit-side Camera Link video timing generator. Pulls pixels from an
//   upstream standard-mode FIFO (1-cycle read latency) and produces
//   FVAL/LVAL/DVAL plus pixel data with programmable blanking. Frame size is
//   taken from app_image_h/app_image_w at each frame start.
//
// Ports:
//   data_clk     in   pixel clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   level; permits starting a new frame
//   app_image_h  in   lines per frame (sampled at frame start)
//   app_image_w  in   pixels per line (sampled at frame start)
//   pix_rd_en    out  upstream FIFO read strobe
//   pix_din      in   upstream FIFO data, valid the cycle after pix_rd_en
//   pix_empty    in   upstream FIFO empty
//   frame_valid  out  FVAL
//   line_valid   out  LVAL
//   data_valid   out  DVAL (same as LVAL)
//   dout         out  pixel data, aligned with line_valid
//   frame_done   out  1-cycle pulse on the cycle frame_valid falls
//   underflow    out  sticky: read attempted while pix_empty

module cameralink_tx_timing #(
    parameter int FV_TO_LV = 2,
    parameter int H_BLANK  = 16,
    parameter int LV_TO_FV = 2,
    parameter int V_BLANK  = 64
) (
    input  logic        data_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] app_image_h,
    input  logic [15:0] app_image_w,
    output logic        pix_rd_en,
    input  logic [15:0] pix_din,
    input  logic        pix_empty,
    output logic        frame_valid,
    output logic        line_valid,
    output logic        data_valid,
    output logic [15:0] dout,
    output logic        frame_done,
    output logic        underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FV_PRE,
        S_LINE,
        S_HBLANK,
        S_FV_POST,
        S_VBLANK
    } state_t;

    localparam logic [15:0] FV_PRE_LAST  = 16'(FV_TO_LV - 1);
    localparam logic [15:0] HBLANK_LAST  = 16'(H_BLANK - 1);
    localparam logic [15:0] FV_POST_LAST = 16'(LV_TO_FV - 1);
    localparam logic [15:0] VBLANK_LAST  = 16'(V_BLANK - 1);

    state_t      state;
    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;
    logic [15:0] blank_cnt;
    logic [15:0] img_h;
    logic [15:0] img_w;

    logic        fv_i;
    logic        lv_i;
    logic        dims_ok;
    logic        start_frame;

    logic        fv_d1;
    logic        lv_d1;
    logic        rd_empty_d1;

    assign fv_i      = (state == S_FV_PRE) || (state == S_LINE) ||
                       (state == S_HBLANK) || (state == S_FV_POST);
    assign lv_i      = (state == S_LINE);
    assign pix_rd_en = lv_i;

    assign dims_ok     = (app_image_h != '0) && (app_image_w != '0);
    // Frame start is possible from idle or at the last V_BLANK cycle; the
    // same term clears the sticky underflow flag.
    assign start_frame = enable && dims_ok &&
                         ((state == S_IDLE) ||
                          ((state == S_VBLANK) && (blank_cnt == VBLANK_LAST)));

    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            blank_cnt <= '0;
            img_h     <= '0;
            img_w     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_frame) begin
                        state     <= S_FV_PRE;
                        img_h     <= app_image_h;
                        img_w     <= app_image_w;
                        line_cnt  <= '0;
                        pix_cnt   <= '0;
                        blank_cnt <= '0;
                    end
                end
                S_FV_PRE: begin
                    if (blank_cnt == FV_PRE_LAST) begin
                        state     <= S_LINE;
                        blank_cnt <= '0;
                        pix_cnt   <= '0;
                    end else begin
                        blank_cnt <= blank_cnt + 16'd1;
                    end
                end
                S_LINE: begin
                    if (pix_cnt == img_w - 16'd1) begin
                        pix_cnt   <= '0;
                        blank_cnt <= '0;
                        line_cnt  <= line_cnt + 16'd1;
                        state     <= (line_cnt == img_h - 16'd1) ? S_FV_POST : S_HBLANK;
                    end else begin
                        pix_cnt <= pix_cnt + 16'd1;
                    end
                end
                S_HBLANK: begin
                    if (blank_cnt == HBLANK_LAST) begin
                        state     <= S_LINE;
                        blank_cnt <= '0;
                        pix_cnt   <= '0;
                    end else begin
                        blank_cnt <= blank_cnt + 16'd1;
                    end
                end
                S_FV_POST: begin
                    if (blank_cnt == FV_POST_LAST) begin
                        state     <= S_VBLANK;
                        blank_cnt <= '0;
                    end else begin
                        blank_cnt <= blank_cnt + 16'd1;
                    end
                end
                S_VBLANK: begin
                    if (blank_cnt == VBLANK_LAST) begin
                        blank_cnt <= '0;
                        pix_cnt   <= '0;
                        if (start_frame) begin
                            state    <= S_FV_PRE;
                            img_h    <= app_image_h;
                            img_w    <= app_image_w;
                            line_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-stage output pipeline: control bits are delayed twice so that a
    // pixel read on cycle t lands on dout at t+2 together with line_valid.
    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_d1       <= 1'b0;
            lv_d1       <= 1'b0;
            rd_empty_d1 <= 1'b0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            data_valid  <= 1'b0;
            dout        <= '0;
            frame_done  <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            fv_d1       <= fv_i;
            lv_d1       <= lv_i;
            rd_empty_d1 <= lv_i && pix_empty;
            frame_valid <= fv_d1;
            line_valid  <= lv_d1;
            data_valid  <= lv_d1;
            // A read from an empty FIFO returns stale data; blank it.
            dout        <= (lv_d1 && !rd_empty_d1) ? pix_din : '0;
            frame_done  <= frame_valid && !fv_d1;
            // Flag is raised in step with the blanked pixel reaching dout;
            // set takes priority over the frame-start clear.
            if (rd_empty_d1) begin
                underflow <= 1'b1;
            end else if (start_frame) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cameralink_tx_timing.sv
// Testbench for cameralink_tx_timing: FIFO model feeding a pixel scoreboard,
// plus per-scenario timing tasks.

module tb_cameralink_tx_timing;

    logic        data_clk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic [15:0] app_image_h = '0;
    logic [15:0] app_image_w = '0;
    logic        pix_rd_en;
    logic [15:0] pix_din  = '0;
    logic        pix_empty = 1'b0;
    logic        frame_valid;
    logic        line_valid;
    logic        data_valid;
    logic [15:0] dout;
    logic        frame_done;
    logic        underflow;

    cameralink_tx_timing #(
        .FV_TO_LV(2),
        .H_BLANK (3),
        .LV_TO_FV(4),
        .V_BLANK (5)
    ) dut (
        .data_clk   (data_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .app_image_h(app_image_h),
        .app_image_w(app_image_w),
        .pix_rd_en  (pix_rd_en),
        .pix_din    (pix_din),
        .pix_empty  (pix_empty),
        .frame_valid(frame_valid),
        .line_valid (line_valid),
        .data_valid (data_valid),
        .dout       (dout),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    always #5 data_clk = ~data_clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [15:0] fifo_next = '0;
    logic [15:0] sb_data[$];
    int unsigned sb_cyc[$];
    bit          sb_en = 1'b0;
    int          pops  = 0;
    logic [15:0] sb_d;
    int unsigned sb_c;

    // Upstream FIFO model: every accepted read pushes the expected pixel
    // (0 for an empty read) and its read cycle onto the scoreboard.
    always @(posedge data_clk) begin
        cyc = cyc + 1;
        if (rst_n === 1'b1 && pix_rd_en === 1'b1) begin
            if (pix_empty) begin
                sb_data.push_back(16'h0000);
                sb_cyc.push_back(cyc - 1);
                #1 pix_din = 16'hDEAD;
            end else begin
                sb_data.push_back(fifo_next);
                sb_cyc.push_back(cyc - 1);
                #1 pix_din = fifo_next;
                fifo_next = fifo_next + 16'd1;
            end
        end
    end

    always @(negedge data_clk) begin
        if (sb_en && rst_n === 1'b1) begin
            checks++;
            if (data_valid !== line_valid) begin
                failures++;
                $display("FAIL dval_eq_lval got=%b exp=%b cyc=%0d", data_valid, line_valid, cyc);
            end
            if (line_valid === 1'b1) begin
                checks++;
                if (sb_data.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_pixel got=%h exp=none cyc=%0d", dout, cyc);
                end else begin
                    sb_d = sb_data.pop_front();
                    sb_c = sb_cyc.pop_front();
                    pops++;
                    if (dout !== sb_d) begin
                        failures++;
                        $display("FAIL pixel_data got=%h exp=%h cyc=%0d", dout, sb_d, cyc);
                    end
                    checks++;
                    if (cyc != sb_c + 2) begin
                        failures++;
                        $display("FAIL pixel_latency got=%0d exp=%0d", cyc - sb_c, 2);
                    end
                end
            end else begin
                checks++;
                if (dout !== 16'h0000) begin
                    failures++;
                    $display("FAIL dout_idle got=%h exp=0000 cyc=%0d", dout, cyc);
                end
            end
        end
    end

    // Frame measurement results.
    int m_fv_hi, m_first_lv, m_nruns, m_fv_lo, m_extra_done;
    int m_run[8];
    int m_gap[8];
    bit m_done_ok, m_timeout;

    // Waits for FVAL high, measures the high phase and its LVAL bursts, then
    // counts low cycles until the next rise or lo_budget.
    task automatic measure_frame(input int lo_budget);
        int n;
        int gap;
        bit prev_lv;
        m_timeout = 1'b0;
        n = 0;
        while (frame_valid !== 1'b1 && n < 500) begin
            @(negedge data_clk);
            n++;
        end
        if (frame_valid !== 1'b1) begin
            m_timeout = 1'b1;
            return;
        end
        m_fv_hi = 0; m_first_lv = -1; m_nruns = 0; m_extra_done = 0;
        gap = 0; prev_lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_run[i] = 0;
            m_gap[i] = 0;
        end
        while (frame_valid === 1'b1 && m_fv_hi < 5000) begin
            if (line_valid === 1'b1) begin
                if (!prev_lv) begin
                    if (m_nruns == 0) m_first_lv = m_fv_hi;
                    else if (m_nruns <= 8) m_gap[m_nruns-1] = gap;
                    m_nruns++;
                end
                if (m_nruns <= 8) m_run[m_nruns-1]++;
                prev_lv = 1'b1;
            end else begin
                if (prev_lv) gap = 0;
                gap++;
                prev_lv = 1'b0;
            end
            if (frame_done === 1'b1) m_extra_done++;
            m_fv_hi++;
            @(negedge data_clk);
        end
        m_done_ok = (frame_done === 1'b1);
        m_fv_lo = 0;
        while (frame_valid !== 1'b1 && m_fv_lo < lo_budget) begin
            if (m_fv_lo > 0 && frame_done === 1'b1) m_extra_done++;
            m_fv_lo++;
            @(negedge data_clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge data_clk);
        checks++; if (pix_rd_en !== 1'b0)   begin failures++; $display("FAIL rst_rd_en got=%b exp=0", pix_rd_en); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL rst_fval got=%b exp=0", frame_valid); end
        checks++; if (line_valid !== 1'b0)  begin failures++; $display("FAIL rst_lval got=%b exp=0", line_valid); end
        checks++; if (data_valid !== 1'b0)  begin failures++; $display("FAIL rst_dval got=%b exp=0", data_valid); end
        checks++; if (dout !== 16'h0000)    begin failures++; $display("FAIL rst_dout got=%h exp=0000", dout); end
        checks++; if (frame_done !== 1'b0)  begin failures++; $display("FAIL rst_done got=%b exp=0", frame_done); end
        checks++; if (underflow !== 1'b0)   begin failures++; $display("FAIL rst_uflow got=%b exp=0", underflow); end
        rst_n = 1'b1;
        repeat (5) @(negedge data_clk);
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL idle_disabled_fval got=%b exp=0", frame_valid); end
    endtask

    task automatic test_back_to_back;
        int n;
        int p0;
        app_image_h = 16'd3;
        app_image_w = 16'd4;
        pix_empty   = 1'b0;
        sb_en       = 1'b1;
        enable      = 1'b1;
        n = 0;
        while (frame_valid !== 1'b1 && n < 20) begin
            @(negedge data_clk);
            n++;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL b2b_start_latency got=%0d exp=3", n); end
        for (int f = 0; f < 3; f++) begin
            p0 = pops;
            measure_frame(50);
            checks++; if (m_timeout) begin failures++; $display("FAIL b2b_timeout got=1 exp=0 frame=%0d", f); end
            checks++; if (m_fv_hi != 24) begin failures++; $display("FAIL b2b_fv_high got=%0d exp=24 frame=%0d", m_fv_hi, f); end
            checks++; if (m_fv_lo != 5) begin failures++; $display("FAIL b2b_fv_low got=%0d exp=5 frame=%0d", m_fv_lo, f); end
            checks++; if (m_first_lv != 2) begin failures++; $display("FAIL b2b_fv_to_lv got=%0d exp=2 frame=%0d", m_first_lv, f); end
            checks++; if (m_nruns != 3) begin failures++; $display("FAIL b2b_lines got=%0d exp=3 frame=%0d", m_nruns, f); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (m_run[i] != 4) begin failures++; $display("FAIL b2b_line_len got=%0d exp=4 line=%0d", m_run[i], i); end
            end
            for (int i = 0; i < 2; i++) begin
                checks++; if (m_gap[i] != 3) begin failures++; $display("FAIL b2b_hblank got=%0d exp=3 gap=%0d", m_gap[i], i); end
            end
            checks++; if (!m_done_ok || m_extra_done != 0) begin failures++; $display("FAIL b2b_frame_done got=%0d/%0d exp=1/0", m_done_ok, m_extra_done); end
            checks++; if (pops - p0 != 12) begin failures++; $display("FAIL b2b_pixel_count got=%0d exp=12", pops - p0); end
        end
    endtask

    task automatic test_underflow;
        int rd;
        bit done;
        done = 1'b0;
        rd = 0;
        fork
            measure_frame(50);
            begin
                for (int i = 0; i < 80 && !done; i++) begin
                    if (pix_rd_en === 1'b1) begin
                        if (rd == 6) begin
                            checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_before got=%b exp=0", underflow); end
                            pix_empty = 1'b1;
                            @(negedge data_clk);
                            pix_empty = 1'b0;
                            checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_plus1 got=%b exp=0", underflow); end
                            @(negedge data_clk);
                            checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_plus2 got=%b exp=1", underflow); end
                            done = 1'b1;
                        end
                        rd++;
                    end
                    if (!done) @(negedge data_clk);
                end
                checks++; if (!done) begin failures++; $display("FAIL uf_inject got=0 exp=1"); end
                for (int i = 0; i < 60 && frame_valid === 1'b1; i++) @(negedge data_clk);
                checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky_at_fall got=%b exp=1", underflow); end
            end
        join
        checks++; if (m_fv_hi != 24 || m_nruns != 3 || m_fv_lo != 5) begin
            failures++; $display("FAIL uf_timing got=%0d/%0d/%0d exp=24/3/5", m_fv_hi, m_nruns, m_fv_lo); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clear_next_frame got=%b exp=0", underflow); end
    endtask

    task automatic test_enable_drop;
        int rd;
        int n;
        bit dropped;
        rd = 0;
        dropped = 1'b0;
        fork
            measure_frame(40);
            begin
                for (int i = 0; i < 80 && !dropped; i++) begin
                    if (pix_rd_en === 1'b1) begin
                        if (rd == 5) begin
                            enable = 1'b0;
                            dropped = 1'b1;
                        end
                        rd++;
                    end
                    if (!dropped) @(negedge data_clk);
                end
            end
        join
        checks++; if (!dropped) begin failures++; $display("FAIL en_drop_point got=0 exp=1"); end
        checks++; if (m_fv_hi != 24 || m_nruns != 3) begin failures++; $display("FAIL en_frame_complete got=%0d/%0d exp=24/3", m_fv_hi, m_nruns); end
        checks++; if (m_fv_lo != 40) begin failures++; $display("FAIL en_no_restart got=%0d exp=40", m_fv_lo); end
        checks++; if (frame_valid !== 1'b0 || pix_rd_en !== 1'b0) begin
            failures++; $display("FAIL en_idle got=%b/%b exp=0/0", frame_valid, pix_rd_en); end
        enable = 1'b1;
        n = 0;
        while (frame_valid !== 1'b1 && n < 20) begin
            @(negedge data_clk);
            n++;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL en_restart_latency got=%0d exp=3", n); end
    endtask

    task automatic test_dims;
        int fv_cnt;
        int rd_cnt;
        enable = 1'b0;
        for (int i = 0; i < 100 && frame_valid === 1'b1; i++) @(negedge data_clk);
        repeat (10) @(negedge data_clk);
        app_image_w = 16'd0;
        app_image_h = 16'd3;
        enable = 1'b1;
        fv_cnt = 0;
        rd_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge data_clk);
            if (frame_valid === 1'b1) fv_cnt++;
            if (pix_rd_en === 1'b1) rd_cnt++;
        end
        checks++; if (fv_cnt != 0 || rd_cnt != 0) begin failures++; $display("FAIL dim_zero_w got=%0d/%0d exp=0/0", fv_cnt, rd_cnt); end
        app_image_w = 16'd2;
        app_image_h = 16'd1;
        fork
            measure_frame(60);
            begin
                for (int i = 0; i < 30 && frame_valid !== 1'b1; i++) @(negedge data_clk);
                repeat (3) @(negedge data_clk);
                app_image_w = 16'd7;
            end
        join
        checks++; if (m_fv_hi != 8) begin failures++; $display("FAIL dim_1x2_fv_high got=%0d exp=8", m_fv_hi); end
        checks++; if (m_nruns != 1 || m_run[0] != 2) begin failures++; $display("FAIL dim_1x2_line got=%0d/%0d exp=1/2", m_nruns, m_run[0]); end
        checks++; if (m_fv_lo != 5) begin failures++; $display("FAIL dim_1x2_fv_low got=%0d exp=5", m_fv_lo); end
        app_image_w = 16'd4;
        app_image_h = 16'd3;
        measure_frame(60);
        checks++; if (m_fv_hi != 13 || m_nruns != 1 || m_run[0] != 7) begin
            failures++; $display("FAIL dim_w_change got=%0d/%0d/%0d exp=13/1/7", m_fv_hi, m_nruns, m_run[0]); end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        while (pix_rd_en !== 1'b1 && n < 100) begin
            @(negedge data_clk);
            n++;
        end
        checks++; if (pix_rd_en !== 1'b1) begin failures++; $display("FAIL rmid_find_line got=%b exp=1", pix_rd_en); end
        repeat (2) @(negedge data_clk);
        #2;
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (pix_rd_en !== 1'b0)   begin failures++; $display("FAIL rmid_rd_en got=%b exp=0", pix_rd_en); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL rmid_fval got=%b exp=0", frame_valid); end
        checks++; if (line_valid !== 1'b0 || data_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_lval_dval got=%b/%b exp=0/0", line_valid, data_valid); end
        checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL rmid_dout got=%h exp=0000", dout); end
        checks++; if (frame_done !== 1'b0 || underflow !== 1'b0) begin
            failures++; $display("FAIL rmid_done_uflow got=%b/%b exp=0/0", frame_done, underflow); end
        repeat (3) @(negedge data_clk);
        sb_data.delete();
        sb_cyc.delete();
        rst_n = 1'b1;
        sb_en = 1'b1;
        n = 0;
        while (frame_valid !== 1'b1 && n < 20) begin
            @(negedge data_clk);
            n++;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL rmid_restart_latency got=%0d exp=3", n); end
        measure_frame(50);
        checks++; if (m_fv_hi != 24 || m_fv_lo != 5 || m_first_lv != 2) begin
            failures++; $display("FAIL rmid_frame got=%0d/%0d/%0d exp=24/5/2", m_fv_hi, m_fv_lo, m_first_lv); end
        checks++; if (m_nruns != 3 || m_run[0] != 4 || m_run[2] != 4 || m_gap[0] != 3 || m_gap[1] != 3) begin
            failures++; $display("FAIL rmid_lines got=%0d/%0d/%0d/%0d/%0d exp=3/4/4/3/3", m_nruns, m_run[0], m_run[2], m_gap[0], m_gap[1]); end
    endtask

    task automatic test_drain;
        enable = 1'b0;
        for (int i = 0; i < 100 && frame_valid === 1'b1; i++) @(negedge data_clk);
        repeat (12) @(negedge data_clk);
        checks++; if (sb_data.size() != 0) begin failures++; $display("FAIL drain_leftover got=%0d exp=0", sb_data.size()); end
        checks++; if (pix_rd_en !== 1'b0 || frame_valid !== 1'b0) begin
            failures++; $display("FAIL drain_idle got=%b/%b exp=0/0", pix_rd_en, frame_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_underflow();
        test_enable_drop();
        test_dims();
        test_reset_mid();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
